ex_mem_register: RTL

EX_MEM_REGISTER -- requirements
Module: ex_mem_register

---
 rtl/ex_mem_register_if.sv | 30 +++
 rtl/ex_mem_register.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ex_mem_register_if.sv
// rtl/ex_mem_register_if.sv - EX/MEM to MEM-stage handshake bus
interface ex_mem_register_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_store_data;
   logic [4:0]  mem_dest;
   logic [3:0]  mem_ctrl;
   logic        mem_zero;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_store_data,
      output mem_dest,
      output mem_ctrl,
      output mem_zero,
      input  mem_ready
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_store_data,
      input  mem_dest,
      input  mem_ctrl,
      input  mem_zero,
      output mem_ready
   );
endinterface

// File: rtl/ex_mem_register.sv
// rtl/ex_mem_register.sv - one-entry EX/MEM pipeline register with ALU-status traps
module ex_mem_register #(
   parameter int TRAP_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [31:0]         ALU_result,
   input  logic [7:0]          ALU_status,
   input  logic                ex_valid,
   output logic                ex_ready,
   input  logic [31:0]         ex_store_data,
   input  logic [4:0]          ex_dest,
   input  logic [4:0]          ex_ctrl,
   input  logic                flush,
   ex_mem_register_if.master   mem,
   output logic                exc_valid,
   output logic [1:0]          exc_code,
   output logic [31:0]         exc_pc_tag,
   input  logic                exc_ack,
   output logic [CNT_W-1:0]    exc_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, TRAP = 2'd2} state_t;

   localparam logic TRAP_ON = (TRAP_EN != 0);

   state_t state;
   state_t state_next;

   logic accept;
   logic trap_ovf;
   logic trap_mis;
   logic trap_hit;
   logic trap_take;
   logic load_dp;
   logic unused_status;

   assign unused_status = ^{ALU_status[6], ALU_status[4], ALU_status[2:0]};

   // flush discards the incoming instruction, so it is never accepted nor trapped
   assign accept    = ex_valid & ex_ready & ~flush;
   assign trap_ovf  = TRAP_ON & ex_ctrl[4] & ALU_status[5];
   assign trap_mis  = TRAP_ON & (ex_ctrl[3] | ex_ctrl[2]) & ALU_status[3];
   assign trap_hit  = trap_ovf | trap_mis;
   assign trap_take = accept & trap_hit;
   assign load_dp   = accept & ~trap_hit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         EMPTY: begin
            if (trap_take)    state_next = TRAP;
            else if (load_dp) state_next = FULL;
         end
         FULL: begin
            if (flush)                               state_next = EMPTY;
            else if (trap_take)                      state_next = TRAP;
            else if (load_dp)                        state_next = FULL;
            else if (mem.mem_valid & mem.mem_ready)  state_next = EMPTY;
         end
         TRAP: begin
            if (exc_ack) state_next = EMPTY;
         end
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      ex_ready      = 1'b0;
      mem.mem_valid = 1'b0;
      exc_valid     = 1'b0;
      unique case (state)
         EMPTY: ex_ready = 1'b1;
         FULL: begin
            ex_ready      = mem.mem_ready;
            mem.mem_valid = 1'b1;
         end
         TRAP:    exc_valid = 1'b1;
         default: ex_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem.mem_addr       <= 32'd0;
         mem.mem_store_data <= 32'd0;
         mem.mem_dest       <= 5'd0;
         mem.mem_ctrl       <= 4'd0;
         mem.mem_zero       <= 1'b0;
         exc_code           <= 2'b00;
         exc_pc_tag         <= 32'd0;
         exc_count          <= '0;
      end else begin
         if (load_dp) begin
            mem.mem_addr       <= ALU_result;
            mem.mem_store_data <= ex_store_data;
            mem.mem_dest       <= ex_dest;
            mem.mem_ctrl       <= ex_ctrl[3:0];
            mem.mem_zero       <= ALU_status[7];
         end
         if (trap_take) begin
            exc_code   <= trap_ovf ? 2'b01 : 2'b10;
            exc_pc_tag <= ALU_result;
            if (exc_count != {CNT_W{1'b1}}) begin
               exc_count <= exc_count + CNT_W'(1);
            end
         end
      end
   end

endmodule
